// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding and reset/bubble constants.
package fetch_unit_pkg;

  localparam int unsigned    XLEN_DEF      = 32;
  localparam logic [31:0]    RESET_PC_DEF  = 32'h0000_0000;
  // addi x0,x0,0
  localparam logic [31:0]    NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory port between the fetch stage (master) and instruction memory (slave).
interface fetch_unit_if #(
  parameter int XLEN = 32
) ();
  // Request is accepted in a cycle where req && gnt; the response arrives as a
  // one-cycle rvalid pulse at least one cycle later, with rdata valid in that cycle.
  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: sync reset > flush (bubble) > hold > load instruction > load bubble.
module fetch_unit_if_id_reg #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            flush,
  input  logic            load,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] pc_plus4_in,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            valid
);

  always_ff @(posedge clk) begin
    if (reset) begin
      instr    <= NOP_INSTR;
      pc       <= '0;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (flush) begin
      // Bubbles keep the last PC pair so only the instruction/valid change
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (en) begin
      if (load) begin
        instr    <= instr_in;
        pc       <= pc_in;
        pc_plus4 <= pc_plus4_in;
        valid    <= 1'b1;
      end else begin
        instr <= NOP_INSTR;
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PCF, issues one outstanding imem request at a time,
// buffers a response while decode stalls and drops responses made stale by a redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              PCSrcE,
  input  logic [XLEN-1:0]   PCTargetE,
  fetch_unit_if.master      imem,
  output logic [XLEN-1:0]   InstrD,
  output logic [XLEN-1:0]   PCD,
  output logic [XLEN-1:0]   PCPlus4D,
  output logic              ValidD,
  output fetch_state_t      dbg_state
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pcf_q, pcf_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] hold_instr_q, hold_instr_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;

  logic            req;
  logic            load;
  logic [XLEN-1:0] load_instr;
  logic [XLEN-1:0] load_pc;

  assign req       = (state_q == S_REQ) && !StallF && !reset;
  assign imem.req  = req;
  assign imem.addr = pcf_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_REQ;
      pcf_q        <= RESET_PC;
      kill_q       <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pcf_q        <= pcf_d;
      kill_q       <= kill_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pcf_d        = pcf_q;
    kill_d       = kill_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    load         = 1'b0;
    load_instr   = imem.rdata;
    load_pc      = pcf_q;

    unique case (state_q)
      S_REQ: begin
        // Nothing accepted yet, so a redirect simply retargets the pending request
        if (PCSrcE) pcf_d = PCTargetE;
        if (req && imem.gnt) begin
          state_d = S_WAIT;
          kill_d  = PCSrcE;
        end
      end
      S_WAIT: begin
        if (PCSrcE) begin
          pcf_d  = PCTargetE;
          kill_d = 1'b1;
        end
        if (imem.rvalid) begin
          if (kill_q || PCSrcE) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else if (!StallD) begin
            load    = 1'b1;
            pcf_d   = pcf_q + XLEN'(4);
            state_d = S_REQ;
          end else begin
            hold_instr_d = imem.rdata;
            hold_pc_d    = pcf_q;
            state_d      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // A redirect wins over delivering the buffered instruction
        if (PCSrcE) begin
          pcf_d   = PCTargetE;
          state_d = S_REQ;
        end else if (!StallD) begin
          load       = 1'b1;
          load_instr = hold_instr_q;
          load_pc    = hold_pc_q;
          pcf_d      = hold_pc_q + XLEN'(4);
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  fetch_unit_if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk         (clk),
    .reset       (reset),
    .en          (!StallD),
    .flush       (FlushD),
    .load        (load),
    .instr_in    (load_instr),
    .pc_in       (load_pc),
    .pc_plus4_in (load_pc + XLEN'(4)),
    .instr       (InstrD),
    .pc          (PCD),
    .pc_plus4    (PCPlus4D),
    .valid       (ValidD)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: imem handshake driven by hand, IF/ID and PCF checked each step.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        gnt, rvalid;
  logic [31:0] rdata;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;
  fetch_state_t dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_unit_if #(.XLEN(32)) imem_bus ();
  assign imem_bus.gnt    = gnt;
  assign imem_bus.rvalid = rvalid;
  assign imem_bus.rdata  = rdata;

  fetch_unit dut (
    .clk       (clk),
    .reset     (reset),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .imem      (imem_bus.master),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance one edge, then settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                          input logic [31:0] pc4, input logic valid);
    chk({tag, ".instr"}, InstrD, instr);
    chk({tag, ".pcd"}, PCD, pc);
    chk({tag, ".pc4"}, PCPlus4D, pc4);
    chk({tag, ".valid"}, 32'(ValidD), 32'(valid));
  endtask

  initial begin
    reset = 1'b1; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = '0;
    gnt = 0; rvalid = 0; rdata = '0;
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst.addr", imem_bus.addr, 32'h0);
    chk("rst.req", 32'(imem_bus.req), 32'd1);
    chk("rst.state", 32'(dbg_state), 32'(S_REQ));
    chk_ifid("rst", NOP, 32'h0, 32'h0, 1'b0);

    // best-case fetch at PC 0
    gnt = 1;
    step();
    gnt = 0; rvalid = 1; rdata = 32'h0050_0093;
    #1;
    chk("f0.state", 32'(dbg_state), 32'(S_WAIT));
    chk("f0.req", 32'(imem_bus.req), 32'd0);
    step();
    rvalid = 0;
    chk_ifid("f0", 32'h0050_0093, 32'h0, 32'h4, 1'b1);
    chk("f0.addr", imem_bus.addr, 32'h4);
    chk("f0.req_next", 32'(imem_bus.req), 32'd1);

    // decode stall while the PC 4 response returns
    gnt = 1;
    step();
    chk_ifid("bub", NOP, 32'h0, 32'h4, 1'b0);
    gnt = 0; rvalid = 1; rdata = 32'h00a0_0113; StallD = 1;
    step();
    rvalid = 0; rdata = 32'hffff_ffff;
    for (int i = 0; i < 2; i++) begin
      chk("hold.state", 32'(dbg_state), 32'(S_HOLD));
      chk("hold.req", 32'(imem_bus.req), 32'd0);
      chk("hold.instr", InstrD, NOP);
      chk("hold.valid", 32'(ValidD), 32'd0);
      step();
    end
    chk("hold.state3", 32'(dbg_state), 32'(S_HOLD));
    StallD = 0;
    step();
    chk_ifid("rel", 32'h00a0_0113, 32'h4, 32'h8, 1'b1);
    chk("rel.addr", imem_bus.addr, 32'h8);
    chk("rel.state", 32'(dbg_state), 32'(S_REQ));

    // redirect after grant at 8: response must be dropped
    gnt = 1;
    step();
    gnt = 0; PCSrcE = 1; PCTargetE = 32'h40;
    step();
    PCSrcE = 0;
    chk("kill.state", 32'(dbg_state), 32'(S_WAIT));
    rvalid = 1; rdata = 32'hdead_beef;
    step();
    rvalid = 0;
    chk("kill.valid", 32'(ValidD), 32'd0);
    chk("kill.instr", InstrD, NOP);
    chk("kill.addr", imem_bus.addr, 32'h40);
    chk("kill.req", 32'(imem_bus.req), 32'd1);
    step();
    chk("kill.valid2", 32'(ValidD), 32'd0);

    // grant withheld, redirect to 0x100 before anything is accepted
    PCSrcE = 1; PCTargetE = 32'h100;
    step();
    PCSrcE = 0;
    chk("retgt.addr", imem_bus.addr, 32'h100);
    chk("retgt.req", 32'(imem_bus.req), 32'd1);
    step();
    chk("retgt.addr2", imem_bus.addr, 32'h100);
    chk("retgt.state", 32'(dbg_state), 32'(S_REQ));
    gnt = 1;
    step();
    gnt = 0; rvalid = 1; rdata = 32'h0000_0297;
    step();
    rvalid = 0;
    chk_ifid("f100", 32'h0000_0297, 32'h100, 32'h104, 1'b1);

    // flush beats stall
    FlushD = 1; StallD = 1; StallF = 1;
    #1;
    chk("flush.req", 32'(imem_bus.req), 32'd0);
    step();
    FlushD = 0; StallD = 0; StallF = 0;
    chk_ifid("flush", NOP, 32'h100, 32'h104, 1'b0);
    chk("flush.addr", imem_bus.addr, 32'h104);

    // redirect in the same cycle as the grant, then wrap-around PC
    gnt = 1; PCSrcE = 1; PCTargetE = 32'hffff_fffc;
    step();
    gnt = 0; PCSrcE = 0;
    chk("gk.state", 32'(dbg_state), 32'(S_WAIT));
    chk("gk.addr", imem_bus.addr, 32'hffff_fffc);
    rvalid = 1; rdata = 32'h1111_1111;
    step();
    rvalid = 0;
    chk("gk.valid", 32'(ValidD), 32'd0);
    chk("gk.state2", 32'(dbg_state), 32'(S_REQ));
    gnt = 1;
    step();
    gnt = 0; rvalid = 1; rdata = 32'h0010_0073;
    step();
    rvalid = 0;
    chk_ifid("wrap", 32'h0010_0073, 32'hffff_fffc, 32'h0, 1'b1);
    chk("wrap.addr", imem_bus.addr, 32'h0);

    // redirect arriving together with rvalid drops that response
    gnt = 1;
    step();
    gnt = 0; rvalid = 1; rdata = 32'h2222_2222; PCSrcE = 1; PCTargetE = 32'h200;
    step();
    rvalid = 0; PCSrcE = 0;
    chk("rvk.valid", 32'(ValidD), 32'd0);
    chk("rvk.addr", imem_bus.addr, 32'h200);
    chk("rvk.state", 32'(dbg_state), 32'(S_REQ));

    // redirect while holding drops the buffer
    gnt = 1;
    step();
    gnt = 0; rvalid = 1; rdata = 32'h3333_3333; StallD = 1;
    step();
    rvalid = 0;
    chk("hk.state", 32'(dbg_state), 32'(S_HOLD));
    StallD = 0; PCSrcE = 1; PCTargetE = 32'h300;
    step();
    PCSrcE = 0;
    chk("hk.valid", 32'(ValidD), 32'd0);
    chk("hk.instr", InstrD, NOP);
    chk("hk.addr", imem_bus.addr, 32'h300);
    chk("hk.state2", 32'(dbg_state), 32'(S_REQ));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
